// File: rtl/comma_aligner.sv
// Serial-to-parallel word aligner: hunts for a comma pattern, verifies repeated
// aligned commas before declaring lock, and drops lock after repeated misaligned commas.
module comma_aligner #(
  parameter int unsigned      SYM_W      = 10,
  parameter logic [SYM_W-1:0] COMMA_P    = SYM_W'(10'b0011111010),
  parameter bit               CHECK_BOTH = 1'b1,
  parameter int unsigned      LOCK_CNT   = 3,
  parameter int unsigned      LOSS_CNT   = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Ser_Data,
  input  logic             i_Bit_Valid,
  input  logic             i_Realign,
  output logic [SYM_W-1:0] o_Sym,
  output logic             o_Sym_Valid,
  output logic             o_Is_Comma,
  output logic             o_Locked,
  output logic [1:0]       o_State
);

  localparam int unsigned         BCNT_W    = $clog2(SYM_W);
  localparam int unsigned         CNT_W     = 4;
  localparam logic [BCNT_W-1:0]   BCNT_LAST = BCNT_W'(SYM_W - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]    LOCK_THR  = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]    LOSS_THR  = CNT_W'(LOSS_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  // Only the low SYM_W-1 bits of the shift register ever reach the next symbol.
  logic [SYM_W-2:0]   r_sr;
  logic [SYM_W-2:0]   w_sr_nxt;
  logic [BCNT_W-1:0]  r_bcnt;
  logic [BCNT_W-1:0]  w_bcnt_nxt;
  logic [CNT_W-1:0]   r_good;
  logic [CNT_W-1:0]   w_good_nxt;
  logic [CNT_W-1:0]   r_bad;
  logic [CNT_W-1:0]   w_bad_nxt;
  logic [SYM_W-1:0]   r_sym;
  logic               r_sym_valid;
  logic               r_is_comma;
  logic               r_locked;

  logic [SYM_W-1:0]   w_next;
  logic               w_match;
  logic               w_boundary;
  logic [CNT_W-1:0]   w_good_inc;
  logic [CNT_W-1:0]   w_bad_inc;
  logic               w_emit;
  logic               w_emit_comma;

  assign w_next     = {r_sr, i_Ser_Data};
  assign w_match    = i_Bit_Valid &&
                      ((w_next == COMMA_P) || (CHECK_BOTH && (w_next == ~COMMA_P)));
  assign w_boundary = i_Bit_Valid && (r_bcnt == BCNT_LAST);
  assign w_good_inc = (r_good == CNT_MAX) ? r_good : r_good + CNT_W'(1);
  assign w_bad_inc  = (r_bad == CNT_MAX) ? r_bad : r_bad + CNT_W'(1);

  // Next-state, counter and symbol-emit decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_sr_nxt     = r_sr;
    w_bcnt_nxt   = r_bcnt;
    w_good_nxt   = r_good;
    w_bad_nxt    = r_bad;
    w_emit       = 1'b0;
    w_emit_comma = 1'b0;

    if (i_Bit_Valid) begin
      w_sr_nxt   = w_next[SYM_W-2:0];
      w_bcnt_nxt = w_boundary ? '0 : r_bcnt + BCNT_W'(1);
    end

    if (i_Realign) begin
      w_state_nxt = ST_HUNT;
      w_bcnt_nxt  = '0;
      w_good_nxt  = '0;
      w_bad_nxt   = '0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (w_match) begin
            w_bcnt_nxt   = '0;
            w_emit       = 1'b1;
            w_emit_comma = 1'b1;
            w_good_nxt   = CNT_W'(1);
            w_state_nxt  = (LOCK_CNT <= 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (w_boundary) begin
            w_emit       = 1'b1;
            w_emit_comma = w_match;
          end
          if (w_match && w_boundary) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc >= LOCK_THR) begin
              w_state_nxt = ST_LOCKED;
              w_bad_nxt   = '0;
            end
          end else if (w_match) begin
            // Comma seen off the boundary: restart the frame on this comma.
            w_bcnt_nxt   = '0;
            w_emit       = 1'b1;
            w_emit_comma = 1'b1;
            w_good_nxt   = CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (w_boundary) begin
            w_emit       = 1'b1;
            w_emit_comma = w_match;
          end
          if (w_match && w_boundary) begin
            w_bad_nxt = '0;
          end else if (w_match) begin
            w_bad_nxt = w_bad_inc;
            if (w_bad_inc >= LOSS_THR) begin
              w_state_nxt  = ST_HUNT;
              w_good_nxt   = '0;
              w_bad_nxt    = '0;
              w_emit       = 1'b0;
              w_emit_comma = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= ST_HUNT;
      r_sr        <= '0;
      r_bcnt      <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_is_comma  <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_sr_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_good      <= w_good_nxt;
      r_bad       <= w_bad_nxt;
      r_sym_valid <= w_emit;
      r_is_comma  <= w_emit & w_emit_comma;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      if (w_emit) begin
        r_sym <= w_next;
      end
    end
  end

  assign o_Sym       = r_sym;
  assign o_Sym_Valid = r_sym_valid;
  assign o_Is_Comma  = r_is_comma;
  assign o_Locked    = r_locked;
  assign o_State     = r_state;

endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: directed lock/loss/gap/realign scenarios plus random
// traffic, checked every cycle against a bit-position reference model.
module tb_comma_aligner;

  localparam int          W      = 10;
  localparam int          LOCK   = 3;
  localparam int          LOSS   = 4;
  localparam logic [9:0]  COMMA  = 10'b0011111010;
  localparam logic [9:0]  ICOMMA = 10'b1100000101;
  localparam logic [9:0]  D2AA   = 10'h2AA;

  logic       clk = 1'b0;
  logic       rst, realign, valid, sdata;
  logic [9:0] sym_a, sym_b;
  logic       sv_a, sv_b, ic_a, ic_b, lk_a, lk_b;
  logic [1:0] st_a, st_b;

  always #5 clk = ~clk;

  comma_aligner #(.SYM_W(10), .COMMA_P(COMMA), .CHECK_BOTH(1'b1),
                  .LOCK_CNT(3), .LOSS_CNT(4)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Ser_Data(sdata), .i_Bit_Valid(valid),
    .i_Realign(realign), .o_Sym(sym_a), .o_Sym_Valid(sv_a),
    .o_Is_Comma(ic_a), .o_Locked(lk_a), .o_State(st_a));

  comma_aligner #(.SYM_W(10), .COMMA_P(COMMA), .CHECK_BOTH(1'b0),
                  .LOCK_CNT(3), .LOSS_CNT(4)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Ser_Data(sdata), .i_Bit_Valid(valid),
    .i_Realign(realign), .o_Sym(sym_b), .o_Sym_Valid(sv_b),
    .o_Is_Comma(ic_b), .o_Locked(lk_b), .o_State(st_b));

  int errs = 0;
  int checks = 0;
  int cyc_n = 0;
  int pulses_b = 0;
  bit gap = 1'b0;

  // Reference model: frame phase tracked as (bits received - anchor) mod W.
  int unsigned m_hist [2];
  int          m_total[2];
  int          m_anchor[2];
  int          m_st   [2];
  int          m_good [2];
  int          m_bad  [2];
  int unsigned m_sym  [2];
  bit          m_sv   [2];
  bit          m_ic   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k, input bit cb);
    bit is_c, on_b, emit, ec;
    emit = 1'b0;
    ec   = 1'b0;
    if (rst) begin
      m_hist[k] = 0; m_total[k] = 0; m_anchor[k] = 0; m_st[k] = 0;
      m_good[k] = 0; m_bad[k] = 0; m_sym[k] = 0; m_sv[k] = 1'b0; m_ic[k] = 1'b0;
      return;
    end
    if (valid) begin
      m_hist[k] = (m_hist[k] * 2 + 32'(sdata)) % 1024;
      m_total[k]++;
    end
    is_c = valid && ((m_hist[k] == 32'(COMMA)) || (cb && (m_hist[k] == 32'(ICOMMA))));
    on_b = valid && (((m_total[k] - m_anchor[k]) % W) == 0);
    if (realign) begin
      m_st[k] = 0; m_good[k] = 0; m_bad[k] = 0; m_anchor[k] = m_total[k];
    end else if (m_st[k] == 0) begin
      if (is_c) begin
        m_anchor[k] = m_total[k]; emit = 1'b1; ec = 1'b1; m_good[k] = 1;
        m_st[k] = (LOCK == 1) ? 2 : 1;
      end
    end else if (m_st[k] == 1) begin
      if (on_b) begin emit = 1'b1; ec = is_c; end
      if (is_c && on_b) begin
        m_good[k] = (m_good[k] >= 15) ? 15 : m_good[k] + 1;
        if (m_good[k] >= LOCK) begin m_st[k] = 2; m_bad[k] = 0; end
      end else if (is_c) begin
        m_anchor[k] = m_total[k]; emit = 1'b1; ec = 1'b1; m_good[k] = 1;
      end
    end else begin
      if (on_b) begin emit = 1'b1; ec = is_c; end
      if (is_c && on_b) begin
        m_bad[k] = 0;
      end else if (is_c) begin
        m_bad[k] = (m_bad[k] >= 15) ? 15 : m_bad[k] + 1;
        if (m_bad[k] >= LOSS) begin
          m_st[k] = 0; m_good[k] = 0; m_bad[k] = 0; emit = 1'b0;
        end
      end
    end
    m_sv[k] = emit;
    m_ic[k] = emit && ec;
    if (emit) m_sym[k] = m_hist[k];
  endtask

  task automatic check_outs();
    chk("a_sym_valid", 32'(sv_a), 32'(m_sv[0]));
    chk("a_sym",       32'(sym_a), m_sym[0]);
    chk("a_state",     32'(st_a), 32'(m_st[0]));
    chk("a_locked",    32'(lk_a), 32'(m_st[0] == 2));
    if (m_sv[0]) chk("a_is_comma", 32'(ic_a), 32'(m_ic[0]));
    chk("b_sym_valid", 32'(sv_b), 32'(m_sv[1]));
    chk("b_sym",       32'(sym_b), m_sym[1]);
    chk("b_state",     32'(st_b), 32'(m_st[1]));
    chk("b_locked",    32'(lk_b), 32'(m_st[1] == 2));
    if (m_sv[1]) chk("b_is_comma", 32'(ic_b), 32'(m_ic[1]));
  endtask

  task automatic cycle(input bit r, input bit ra, input bit v, input bit d);
    rst = r; realign = ra; valid = v; sdata = d;
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
    cyc_n++;
    if (sv_b) pulses_b++;
    check_outs();
  endtask

  task automatic vbit(input bit d);
    if (gap) cycle(1'b0, 1'b0, 1'b0, 1'($urandom % 2));
    cycle(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic send(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) vbit(s[i]);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'($urandom % 2), 1'b1, 1'(i % 2));
      chk("rst_sym_valid", 32'(sv_a), 32'd0);
      chk("rst_state",     32'(st_a), 32'd0);
      chk("rst_sym",       32'(sym_a), 32'd0);
    end
    pulses_b = 0;
  endtask

  // Junk, three commas of the given polarity, then 2AA data; checks dut_a.
  task automatic lock_seq(input logic [9:0] c);
    int last;
    vbit(1'b1); vbit(1'b1); vbit(1'b0);
    send(c);
    chk("first_pulse",  32'(sv_a), 32'd1);
    chk("first_comma",  32'(ic_a), 32'd1);
    chk("first_state",  32'(st_a), 32'd1);
    send(c);
    for (int i = 9; i >= 0; i--) begin
      vbit(c[i]);
      if (i == 1) chk("pre_lock", 32'(lk_a), 32'd0);
    end
    chk("lock", 32'(lk_a), 32'd1);
    last = cyc_n;
    for (int n = 0; n < 4; n++) begin
      send(D2AA);
      chk("data_pulse",   32'(sv_a), 32'd1);
      chk("data_sym",     32'(sym_a), 32'(D2AA));
      chk("data_comma",   32'(ic_a), 32'd0);
      chk("data_spacing", 32'(cyc_n - last), gap ? 32'd20 : 32'd10);
      last = cyc_n;
    end
  endtask

  initial begin
    logic [9:0] cw;
    logic [9:0] hd;
    int         r;
    rst = 1'b1; realign = 1'b0; valid = 1'b0; sdata = 1'b0;

    // Reset and basic lock.
    do_reset();
    lock_seq(COMMA);

    // Inverted-polarity commas: only the CHECK_BOTH=1 instance may lock.
    do_reset();
    lock_seq(ICOMMA);
    chk("cb0_state",  32'(st_b), 32'd0);
    chk("cb0_pulses", 32'(pulses_b), 32'd0);

    // Loss of lock after four misaligned commas.
    do_reset();
    lock_seq(COMMA);
    vbit(1'b1); vbit(1'b1); vbit(1'b0);
    for (int n = 0; n < 4; n++) begin
      send(COMMA);
      chk("loss", 32'(lk_a), (n < 3) ? 32'd1 : 32'd0);
    end

    // An aligned comma between misaligned ones resets the loss count.
    do_reset();
    lock_seq(COMMA);
    vbit(1'b1); vbit(1'b1); vbit(1'b0);
    for (int n = 0; n < 3; n++) begin send(COMMA); chk("hold1", 32'(lk_a), 32'd1); end
    for (int i = 0; i < 7; i++) vbit(1'(i % 2 == 0));
    send(COMMA);
    chk("aligned_comma", 32'(ic_a & sv_a), 32'd1);
    vbit(1'b1); vbit(1'b1); vbit(1'b0);
    for (int n = 0; n < 3; n++) begin send(COMMA); chk("hold2", 32'(lk_a), 32'd1); end

    // Same lock with idle cycles between valid bits.
    gap = 1'b1;
    do_reset();
    lock_seq(COMMA);
    gap = 1'b0;

    // Realign on the last bit of a misaligned comma at bcnt=5.
    do_reset();
    lock_seq(COMMA);
    hd = 10'b1010100011;
    send(hd);
    cw = COMMA;
    for (int i = 5; i >= 1; i--) vbit(cw[i]);
    cycle(1'b0, 1'b1, 1'b1, cw[0]);
    chk("realign_state", 32'(st_a), 32'd0);
    chk("realign_pulse", 32'(sv_a), 32'd0);
    chk("realign_lock",  32'(lk_a), 32'd0);
    send(COMMA);
    chk("relock_verify", 32'(st_a), 32'd1);
    send(COMMA);
    send(COMMA);
    chk("relock", 32'(lk_a), 32'd1);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      gap = ($urandom % 4) == 0;
      r = int'($urandom_range(0, 99));
      if (r < 35)      send(COMMA);
      else if (r < 45) send(ICOMMA);
      else if (r < 60) send(D2AA);
      else if (r < 80) send(10'($urandom));
      else if (r < 94) begin
        for (int i = 0; i < int'($urandom_range(1, 7)); i++) vbit(1'($urandom % 2));
      end
      else if (r < 98) cycle(1'b0, 1'b1, 1'($urandom % 2), 1'($urandom % 2));
      else             cycle(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    end
    gap = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
